seg_pipe_adder: RTL and testbench

SEG_PIPE_ADDER -- requirements
Module: seg_pipe_adder

---
 rtl/seg_pipe_adder.sv | 124 ++++++++++++
 tb/tb_seg_pipe_adder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder: segmented pipelined adder. Each stage adds SEG bits, and the carry is registered between stages.
// Latency: STAGES = WIDTH/SEG cycles from acceptance to out_valid. Throughput is one beat per cycle.
// Backpressure: every stage advances together when !out_valid || out_ready. in_ready is that advance term.
//
// Ports: clk, resetn (async, active-low); in_valid/in_ready with a, b, cin;
//        out_valid/out_ready with sum, cout (and ovf when SEG_PIPE_ADDER_OVF_EN is defined).
// Optional feature macro: SEG_PIPE_ADDER_OVF_EN adds the registered two's-complement overflow output ovf.
// WIDTH must be an integer multiple of SEG.
module seg_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SEG_PIPE_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int STAGES = WIDTH / SEG;

    // A single advance term drives the whole pipe. Bubbles move along with beats,
    // so the design keeps beat order and never collapses a bubble.
    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_st
            // Operand bits not yet added when a beat enters stage k.
            // The lowest SEG of these bits are added in this stage.
            localparam int REM = WIDTH - k*SEG;

            logic [REM-1:0]       w_a;
            logic [REM-1:0]       w_b;
            logic                 w_ci;
            logic                 w_vi;
            logic [SEG:0]         w_add;
            logic [(k+1)*SEG-1:0] w_sum_nxt;

            logic                 r_vld;
            logic [(k+1)*SEG-1:0] r_sum;
            logic                 r_cy;

            assign w_add = {1'b0, w_a[SEG-1:0]} + {1'b0, w_b[SEG-1:0]} + {{SEG{1'b0}}, w_ci};

            if (k == 0) begin : g_in
                assign w_a       = a;
                assign w_b       = b;
                assign w_ci      = cin;
                assign w_vi      = in_valid;
                assign w_sum_nxt = w_add[SEG-1:0];
            end else begin : g_in
                assign w_a       = g_st[k-1].g_rest.r_a;
                assign w_b       = g_st[k-1].g_rest.r_b;
                assign w_ci      = g_st[k-1].r_cy;
                assign w_vi      = g_st[k-1].r_vld;
                // The new segment goes above the segments that earlier stages completed.
                assign w_sum_nxt = {w_add[SEG-1:0], g_st[k-1].r_sum};
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_vld <= 1'b0;
                    r_sum <= '0;
                    r_cy  <= 1'b0;
                end else if (w_adv) begin
                    r_vld <= w_vi;
                    r_sum <= w_sum_nxt;
                    r_cy  <= w_add[SEG];
                end
            end

            // Upper operand segments are carried forward only while some remain to add.
            if (REM > SEG) begin : g_rest
                logic [REM-SEG-1:0] r_a;
                logic [REM-SEG-1:0] r_b;

                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (w_adv) begin
                        r_a <= w_a[REM-1:SEG];
                        r_b <= w_b[REM-1:SEG];
                    end
                end
            end

`ifdef SEG_PIPE_ADDER_OVF_EN
            // The operand MSBs and the sum MSB all fall in the last segment,
            // so the last stage can compute overflow directly.
            if (k == STAGES-1) begin : g_ovf
                logic r_ovf;

                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) begin
                        r_ovf <= 1'b0;
                    end else if (w_adv) begin
                        r_ovf <= (w_a[SEG-1] == w_b[SEG-1]) && (w_add[SEG-1] != w_a[SEG-1]);
                    end
                end
            end
`endif
        end
    endgenerate

    assign out_valid = g_st[STAGES-1].r_vld;
    assign sum       = g_st[STAGES-1].r_sum;
    assign cout      = g_st[STAGES-1].r_cy;
`ifdef SEG_PIPE_ADDER_OVF_EN
    assign ovf       = g_st[STAGES-1].g_ovf.r_ovf;
`endif

endmodule

// File: tb/tb_seg_pipe_adder.sv
// tb_seg_pipe_adder: checks seg_pipe_adder in four geometries (32/16, 32/8, 32/32, 64/16).
// Instance 0 (32/16) runs the directed vectors and the stall and reset sequences.
// All four instances then run random traffic against an arithmetic reference model.
module tb_seg_pipe_adder;
    localparam int NI = 4;
    localparam int CW  [NI] = '{32, 32, 32, 64};
    localparam int CS  [NI] = '{16,  8, 32, 16};
    localparam int CST [NI] = '{ 2,  4,  1,  4};
    localparam int NV = 10;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
        int          w;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        c;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [63:0] t_a   [NI];
    logic [63:0] t_b   [NI];
    logic        t_ci  [NI];
    logic        t_iv  [NI];
    logic        t_ir  [NI];
    logic        t_ov  [NI];
    logic        t_or  [NI];
    logic [63:0] t_sum [NI];
    logic        t_co  [NI];
`ifdef SEG_PIPE_ADDER_OVF_EN
    logic        t_of  [NI];
`endif

    int n_run  = 0;
    int n_fail = 0;
    int win    = 0;

    exp_t        sb        [NI][$];
    logic        stall_prev[NI];
    logic [63:0] sum_prev  [NI];
    logic        co_prev   [NI];
    vec_t        vt        [NV];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int W = CW[gi];
        logic [W-1:0] w_sum;
        seg_pipe_adder #(.WIDTH(W), .SEG(CS[gi])) u_dut (
            .clk       (clk),
            .resetn    (resetn),
            .in_valid  (t_iv[gi]),
            .in_ready  (t_ir[gi]),
            .a         (t_a[gi][W-1:0]),
            .b         (t_b[gi][W-1:0]),
            .cin       (t_ci[gi]),
            .out_valid (t_ov[gi]),
            .out_ready (t_or[gi]),
            .sum       (w_sum),
`ifdef SEG_PIPE_ADDER_OVF_EN
            .ovf       (t_of[gi]),
`endif
            .cout      (t_co[gi])
        );
        assign t_sum[gi] = 64'(w_sum);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] wmask(input int w);
        return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: plain (a + b + cin) over WIDTH+1 bits, independent of segmentation.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input int wn);
        exp_t        r;
        logic [64:0] full;
        full = {1'b0, a} + {1'b0, b} + {64'd0, ci};
        r.s  = full[63:0] & wmask(w);
        r.c  = full[w];
        r.o  = (a[w-1] == b[w-1]) && (r.s[w-1] != a[w-1]);
        r.w  = wn;
        return r;
    endfunction

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            t_a[i] = '0; t_b[i] = '0; t_ci[i] = 1'b0; t_iv[i] = 1'b0; t_or[i] = 1'b1;
        end
    endtask

    task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic ci);
        t_a[0] = 64'(a); t_b[0] = 64'(b); t_ci[0] = ci; t_iv[0] = 1'b1;
    endtask

    function automatic logic [63:0] rand_op(input logic [63:0] m);
        int r;
        r = $urandom_range(0, 7);
        if (r == 0)      return m;
        else if (r == 1) return 64'd0;
        else             return {$urandom(), $urandom()} & m;
    endfunction

    // One window = negedge to negedge. Inputs are driven first and outputs sampled 1 time unit later.
    // A beat counts as accepted in the window where in_valid && in_ready.
    task automatic run_random(input int nwin, input bit stall, input bit feed, input bit chk_lat);
        exp_t e;
        for (int n = 0; n < nwin; n++) begin
            @(negedge clk);
            win++;
            for (int i = 0; i < NI; i++) begin
                t_or[i] = stall ? ($urandom_range(0, 9) < 6) : 1'b1;
                t_iv[i] = feed && ($urandom_range(0, 3) != 0);
                t_a[i]  = rand_op(wmask(CW[i]));
                t_b[i]  = rand_op(wmask(CW[i]));
                t_ci[i] = 1'($urandom_range(0, 1));
            end
            #1;
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("i%0d_in_ready", i), t_ir[i], !t_ov[i] || t_or[i]);
                if (stall_prev[i]) begin
                    chk($sformatf("i%0d_hold_valid", i), t_ov[i], 1);
                    chk($sformatf("i%0d_hold_sum", i), t_sum[i], sum_prev[i]);
                    chk($sformatf("i%0d_hold_cout", i), t_co[i], co_prev[i]);
                end
                if (t_ov[i]) begin
                    if (sb[i].size() == 0) begin
                        chk($sformatf("i%0d_spurious_valid", i), t_ov[i], 0);
                    end else begin
                        e = sb[i][0];
                        chk($sformatf("i%0d_sum", i), t_sum[i], e.s);
                        chk($sformatf("i%0d_cout", i), t_co[i], e.c);
`ifdef SEG_PIPE_ADDER_OVF_EN
                        chk($sformatf("i%0d_ovf", i), t_of[i], e.o);
`endif
                        if (chk_lat) chk($sformatf("i%0d_latency", i), win - e.w, CST[i]);
                        if (t_or[i]) void'(sb[i].pop_front());
                    end
                end
                stall_prev[i] = t_ov[i] && !t_or[i];
                sum_prev[i]   = t_sum[i];
                co_prev[i]    = t_co[i];
                if (t_iv[i] && t_ir[i])
                    sb[i].push_back(model(CW[i], t_a[i], t_b[i], t_ci[i], win));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        exp_t sx [4];
        int   nacc;
        int   ngot;

        vt[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0};
        vt[1] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0};
        vt[2] = '{32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_999A, 1'b0};
        vt[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        vt[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vt[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vt[6] = '{32'h0000_FFFF, 32'hFFFF_0000, 1'b1, 32'h0000_0000, 1'b1};
        vt[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
        vt[8] = '{32'h0001_FFFF, 32'h0000_FFFF, 1'b0, 32'h0002_FFFE, 1'b0};
        vt[9] = '{32'hFFFF_0000, 32'h0001_0000, 1'b0, 32'h0000_0000, 1'b1};

        for (int i = 0; i < NI; i++) begin
            stall_prev[i] = 1'b0; sum_prev[i] = '0; co_prev[i] = 1'b0;
        end

        // Reset state.
        resetn = 1'b0;
        idle_all();
        #2;
        chk("rst_out_valid", t_ov[0], 0);
        chk("rst_sum", t_sum[0], 0);
        chk("rst_cout", t_co[0], 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1 chk("rst_release_in_ready", t_ir[0], 1);

        // All-ones + 1: the result appears exactly two windows after acceptance.
        @(negedge clk); drive0(32'hFFFF_FFFF, 32'h1, 1'b0);
        @(negedge clk); t_iv[0] = 1'b0;
        #1 chk("wrap_early_valid", t_ov[0], 0);
        @(negedge clk);
        #1;
        chk("wrap_valid", t_ov[0], 1);
        chk("wrap_sum", t_sum[0], 0);
        chk("wrap_cout", t_co[0], 1);
        @(negedge clk);
        #1 chk("wrap_after_valid", t_ov[0], 0);

        // Back-to-back table vectors: one result per window, latency 2.
        for (int i = 0; i < NV + 2; i++) begin
            @(negedge clk);
            if (i < NV) drive0(vt[i].a, vt[i].b, vt[i].ci);
            else        t_iv[0] = 1'b0;
            #1;
            if (i >= 2) begin
                chk($sformatf("vec%0d_valid", i-2), t_ov[0], 1);
                chk($sformatf("vec%0d_sum", i-2), t_sum[0], 64'(vt[i-2].s));
                chk($sformatf("vec%0d_cout", i-2), t_co[0], vt[i-2].c);
            end else begin
                chk($sformatf("vec_pre%0d_valid", i), t_ov[0], 0);
            end
        end
        @(negedge clk);
        #1 chk("vec_tail_valid", t_ov[0], 0);

        // Stall: out_ready low for five windows with the pipe full.
        for (int k = 0; k < 4; k++)
            sx[k] = model(32, 64'(32'h1111_1111 * (k + 1)), 64'h0101_0101, 1'(k), 0);
        nacc = 0;
        ngot = 0;
        for (int w = 0; w < 14; w++) begin
            @(negedge clk);
            t_or[0] = !(w >= 2 && w <= 6);
            if (nacc < 4) drive0(32'h1111_1111 * (nacc + 1), 32'h0101_0101, 1'(nacc));
            else          t_iv[0] = 1'b0;
            #1;
            if (!t_or[0]) begin
                chk("stall_in_ready", t_ir[0], 0);
                chk("stall_valid", t_ov[0], 1);
            end
            if (t_ov[0]) begin
                if (ngot >= 4) begin
                    chk("stall_dup_valid", t_ov[0], 0);
                end else begin
                    chk($sformatf("stall_sum%0d", ngot), t_sum[0], sx[ngot].s);
                    chk($sformatf("stall_cout%0d", ngot), t_co[0], sx[ngot].c);
                    if (t_or[0]) ngot++;
                end
            end
            if (t_iv[0] && t_ir[0]) nacc++;
        end
        chk("stall_beats_out", ngot, 4);
        t_or[0] = 1'b1;
        t_iv[0] = 1'b0;

        // Reset mid-cycle with two beats in flight.
        @(negedge clk); drive0(32'd5, 32'd6, 1'b0);
        @(negedge clk); drive0(32'd7, 32'd8, 1'b0);
        @(negedge clk); t_iv[0] = 1'b0;
        #1;
        chk("prerst_valid", t_ov[0], 1);
        chk("prerst_sum", t_sum[0], 11);
        #1 resetn = 1'b0;
        #1;
        chk("midrst_valid", t_ov[0], 0);
        chk("midrst_sum", t_sum[0], 0);
        chk("midrst_cout", t_co[0], 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1 chk("postrst_in_ready", t_ir[0], 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 chk("postrst_no_stale", t_ov[0], 0);
        end

`ifdef SEG_PIPE_ADDER_OVF_EN
        @(negedge clk); drive0(32'h7FFF_FFFF, 32'h1, 1'b0);
        @(negedge clk); drive0(32'hFFFF_FFFF, 32'h1, 1'b0);
        @(negedge clk); t_iv[0] = 1'b0;
        #1;
        chk("ovf_pos_ovf", t_of[0], 1);
        chk("ovf_pos_sum", t_sum[0], 64'h8000_0000);
        @(negedge clk);
        #1;
        chk("ovf_wrap_ovf", t_of[0], 0);
        chk("ovf_wrap_sum", t_sum[0], 0);
`endif

        // Random traffic on all geometries.
        run_random(300, 1'b0, 1'b1, 1'b1);
        run_random(400, 1'b1, 1'b1, 1'b0);
        run_random(20,  1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NI; i++)
            chk($sformatf("i%0d_drained", i), sb[i].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
